// File: rtl/fork_join_ctrl.sv
// rtl/fork_join_ctrl.sv - fork/join controller launching timed channels under JOIN, JOIN_ANY or JOIN_NONE policies.
module fork_join_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    start_ready,
  input  logic [1:0]              mode,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] dur,
  input  logic                    abort,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       ch_done,
  output logic                    join_done,
  output logic [NUM_CH-1:0]       collide,
  output logic                    idle
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic              any_mode, any_mode_nxt;
  logic [NUM_CH-1:0] pending, pending_nxt;
  logic [NUM_CH-1:0] live, launch;
  logic              accept, join_nxt;
  logic [CNT_W-1:0]  cnt [NUM_CH];

  // A channel finishing this cycle is free to be relaunched by the same accept.
  assign live        = busy & ~ch_done;
  assign launch      = ch_en & ~live;
  assign start_ready = (state == IDLE);
  assign accept      = start && start_ready && !abort;
  assign idle        = start_ready && (busy == '0);

  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending & ~ch_done;
    any_mode_nxt = any_mode;
    join_nxt     = 1'b0;
    if (abort) begin
      state_nxt   = IDLE;
      pending_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          pending_nxt = '0;
          if (accept) begin
            if (launch == '0 || mode == 2'b10) begin
              join_nxt = 1'b1;
            end else begin
              state_nxt    = RUN;
              pending_nxt  = launch;
              any_mode_nxt = (mode == 2'b01);
            end
          end
        end
        RUN: begin
          if (any_mode ? |(pending & ch_done) : ((pending & ~ch_done) == '0)) begin
            join_nxt    = 1'b1;
            state_nxt   = IDLE;
            pending_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      any_mode  <= 1'b0;
      pending   <= '0;
      join_done <= 1'b0;
      collide   <= '0;
    end else begin
      state     <= state_nxt;
      any_mode  <= any_mode_nxt;
      pending   <= pending_nxt;
      join_done <= join_nxt;
      collide   <= accept ? (ch_en & live) : '0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_done[g] = busy[g] && (cnt[g] == '0);

    // Counter stops at zero: reaching zero ends the channel instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy[g] <= 1'b0;
        cnt[g]  <= '0;
      end else if (abort) begin
        busy[g] <= 1'b0;
        cnt[g]  <= '0;
      end else if (accept && launch[g]) begin
        busy[g] <= 1'b1;
        cnt[g]  <= dur[g*CNT_W +: CNT_W];
      end else if (busy[g]) begin
        if (cnt[g] == '0) busy[g] <= 1'b0;
        else              cnt[g]  <= cnt[g] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// tb/tb_fork_join_ctrl.sv - self-checking bench for fork_join_ctrl using an end-time based reference model.
module tb_fork_join_ctrl;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n, start, abort;
  logic [1:0]     mode;
  logic [N-1:0]   ch_en;
  logic [N*W-1:0] dur;
  logic           start_ready, join_done, idle;
  logic [N-1:0]   busy, ch_done, collide;

  fork_join_ctrl #(.NUM_CH(N), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready), .mode(mode),
    .ch_en(ch_en), .dur(dur), .abort(abort), .busy(busy), .ch_done(ch_done),
    .join_done(join_done), .collide(collide), .idle(idle)
  );

  always #5 clk = ~clk;

  // Model: each channel is busy over cycles [st, en]; join completes at a precomputed cycle.
  int         passed = 0, total = 0, now = 0;
  int         st [N], en [N];
  bit         act [N], nodone [N];
  int         join_at, col_at;
  bit         waiting;
  logic [N-1:0] col_exp;

  int         base, rec_join, rec_join_last, join_cnt, rec_col;
  int         rec_done [N];
  logic [N-1:0] rec_col_val;

  typedef struct {
    logic [1:0] m;
    logic [3:0] e;
    logic [31:0] d;
    int j, e0, e1, e2, e3;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s cycle %0d: got %0h want %0h", name, now, got, want);
  endtask

  function automatic logic [N-1:0] exp_busy(input int c);
    logic [N-1:0] b = '0;
    for (int i = 0; i < N; i++) b[i] = act[i] && st[i] <= c && c <= en[i];
    return b;
  endfunction

  function automatic logic [N-1:0] exp_done(input int c);
    logic [N-1:0] b = exp_busy(c);
    logic [N-1:0] d = '0;
    for (int i = 0; i < N; i++) d[i] = b[i] && c == en[i] && !nodone[i];
    return d;
  endfunction

  function automatic logic exp_ready(input int c);
    return !(waiting && c < join_at);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin act[i] = 0; nodone[i] = 0; st[i] = 0; en[i] = 0; end
    join_at = -1; col_at = -1; waiting = 0; col_exp = '0;
  endtask

  task automatic clear_rec();
    rec_join = -1; rec_join_last = -1; join_cnt = 0; rec_col = -1; rec_col_val = '0;
    for (int i = 0; i < N; i++) rec_done[i] = -1;
  endtask

  task automatic check_cycle();
    logic [N-1:0] b, d;
    logic r;
    b = exp_busy(now); d = exp_done(now); r = exp_ready(now);
    chk("busy", 16'(busy), 16'(b));
    chk("ch_done", 16'(ch_done), 16'(d));
    chk("join_done", 16'(join_done), 16'(now == join_at));
    chk("collide", 16'(collide), 16'((now == col_at) ? col_exp : '0));
    chk("start_ready", 16'(start_ready), 16'(r));
    chk("idle", 16'(idle), 16'(r && b == '0));
    if (join_done) begin
      join_cnt++;
      rec_join_last = now - base;
      if (rec_join < 0) rec_join = now - base;
    end
    for (int i = 0; i < N; i++) if (ch_done[i] && rec_done[i] < 0) rec_done[i] = now - base;
    if (collide != '0 && rec_col < 0) begin rec_col = now - base; rec_col_val = collide; end
  endtask

  task automatic model_step();
    logic [N-1:0] b, d, launch;
    int mx, mn;
    if (abort) begin
      for (int i = 0; i < N; i++)
        if (act[i] && en[i] > now) begin en[i] = now; nodone[i] = 1; end
      if (join_at > now) join_at = -1;
      if (col_at > now) col_at = -1;
      waiting = 0;
    end else if (start && exp_ready(now)) begin
      b = exp_busy(now); d = exp_done(now);
      launch = ch_en & ~(b & ~d);
      col_exp = ch_en & b & ~d; col_at = now + 1;
      mx = -1; mn = 1 << 30;
      for (int i = 0; i < N; i++) if (launch[i]) begin
        act[i] = 1; nodone[i] = 0; st[i] = now + 1;
        en[i] = now + 1 + int'(dur[i*W +: W]);
        if (en[i] > mx) mx = en[i];
        if (en[i] < mn) mn = en[i];
      end
      if (launch == '0 || mode == 2'b10) begin join_at = now + 1; waiting = 0; end
      else begin waiting = 1; join_at = (mode == 2'b01) ? mn + 1 : mx + 1; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    model_step();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 16'(busy), 16'h0);
    chk({tag, "_ch_done"}, 16'(ch_done), 16'h0);
    chk({tag, "_join_done"}, 16'(join_done), 16'h0);
    chk({tag, "_collide"}, 16'(collide), 16'h0);
    chk({tag, "_start_ready"}, 16'(start_ready), 16'h1);
    chk({tag, "_idle"}, 16'(idle), 16'h1);
  endtask

  task automatic run_vec(input int k);
    clear_rec();
    mode = vecs[k].m; ch_en = vecs[k].e; dur = vecs[k].d; start = 1'b1;
    base = now + 1;
    tick();
    start = 1'b0; ch_en = '0;
    repeat (40) tick();
    chk("tbl_join_t", 16'(rec_join), 16'(vecs[k].j));
    chk("tbl_join_cnt", 16'(join_cnt), 16'd1);
    chk("tbl_done0", 16'(rec_done[0]), 16'(vecs[k].e0));
    chk("tbl_done1", 16'(rec_done[1]), 16'(vecs[k].e1));
    chk("tbl_done2", 16'(rec_done[2]), 16'(vecs[k].e2));
    chk("tbl_done3", 16'(rec_done[3]), 16'(vecs[k].e3));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'b00, 4'b0011, {8'd0, 8'd0, 8'd30, 8'd20}, 31, 20, 30, -1, -1};
    vecs[1] = '{2'b10, 4'b0011, {8'd0, 8'd0, 8'd30, 8'd20}, 0, 20, 30, -1, -1};
    vecs[2] = '{2'b01, 4'b0111, {8'd0, 8'd2, 8'd9, 8'd5}, 3, 5, 9, 2, -1};
    vecs[3] = '{2'b00, 4'b1000, {8'd0, 8'd0, 8'd0, 8'd0}, 1, -1, -1, -1, 0};
    vecs[4] = '{2'b00, 4'b0000, {8'd5, 8'd5, 8'd5, 8'd5}, 0, -1, -1, -1, -1};
    vecs[5] = '{2'b11, 4'b0101, {8'd0, 8'd7, 8'd0, 8'd3}, 8, 3, -1, 7, -1};
    vecs[6] = '{2'b01, 4'b0011, {8'd0, 8'd0, 8'd4, 8'd4}, 5, 4, 4, -1, -1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; ch_en = '0; dur = '0;
    model_reset(); clear_rec(); base = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(k);

    // JOIN_NONE channel still running collides with a later JOIN fork.
    clear_rec();
    mode = 2'b10; ch_en = 4'b0001; dur = {8'd0, 8'd0, 8'd0, 8'd10}; start = 1'b1;
    base = now + 1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    mode = 2'b00; ch_en = 4'b0011; dur = {8'd0, 8'd0, 8'd4, 8'd10}; start = 1'b1;
    tick();
    start = 1'b0; ch_en = '0;
    repeat (12) tick();
    chk("col_time", 16'(rec_col), 16'd4);
    chk("col_value", 16'(rec_col_val), 16'b0001);
    chk("col_done1", 16'(rec_done[1]), 16'd8);
    chk("col_done0", 16'(rec_done[0]), 16'd10);
    chk("col_join_t", 16'(rec_join_last), 16'd9);
    chk("col_join_cnt", 16'(join_cnt), 16'd2);

    // Abort with a simultaneous start during a JOIN.
    clear_rec();
    mode = 2'b00; ch_en = 4'b0001; dur = {8'd0, 8'd0, 8'd0, 8'd20}; start = 1'b1;
    base = now + 1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    abort = 1'b1; start = 1'b1; ch_en = 4'b0010; dur = {8'd0, 8'd0, 8'd3, 8'd20};
    tick();
    abort = 1'b0; start = 1'b0; ch_en = '0;
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_ready", 16'(start_ready), 16'h1);
    repeat (25) tick();
    chk("abort_join_cnt", 16'(join_cnt), 16'd0);
    chk("abort_dropped", 16'(rec_done[1]), 16'hFFFF);

    // Asynchronous reset in the middle of a run, then a fresh fork.
    mode = 2'b00; ch_en = 4'b0011; dur = {8'd0, 8'd0, 8'd20, 8'd20}; start = 1'b1;
    tick();
    start = 1'b0; ch_en = '0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    now++;
    run_vec(3);

    repeat (400) begin
      start = 1'($urandom_range(0, 1));
      mode  = 2'($urandom_range(0, 3));
      ch_en = 4'($urandom);
      for (int i = 0; i < N; i++) dur[i*W +: W] = 8'($urandom_range(0, 15));
      abort = ($urandom_range(0, 29) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; ch_en = '0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
